// File: rtl/port_bank.sv
// Three ext->core and three core->ext FIFOs with strobe-edge core access.
// Optional PORT_BANK_ERR_CNT_EN adds a saturating err_cnt output.
module port_bank #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             lclock,
  input  logic             reset_n,
  input  logic             core_read,
  input  logic [1:0]       core_in_addr,
  output logic [2:0]       core_in_ready,
  output logic [WIDTH-1:0] core_data_in,
  input  logic             core_write,
  input  logic [1:0]       core_out_addr,
  input  logic [WIDTH-1:0] core_data_out,
  output logic [2:0]       core_out_ready,
  input  logic             ext_wr_en,
  input  logic [1:0]       ext_wr_port,
  input  logic [WIDTH-1:0] ext_wr_data,
  output logic             ext_wr_full,
  input  logic             ext_rd_en,
  input  logic [1:0]       ext_rd_port,
  output logic [WIDTH-1:0] ext_rd_data,
  output logic             ext_rd_empty,
  output logic             err
`ifdef PORT_BANK_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [AW:0]   CONE = 1;
  localparam logic [AW:0]   CFULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_in_mem  [3][DEPTH];
  logic [WIDTH-1:0] r_out_mem [3][DEPTH];
  logic [AW-1:0]    r_in_wp   [3];
  logic [AW-1:0]    r_in_rp   [3];
  logic [AW:0]      r_in_cnt  [3];
  logic [AW-1:0]    r_out_wp  [3];
  logic [AW-1:0]    r_out_rp  [3];
  logic [AW:0]      r_out_cnt [3];

  logic r_read_q;
  logic r_write_q;
  logic r_rd_arm;
  logic r_wr_arm;
  logic r_err;

  logic       w_rd_fall;
  logic       w_wr_fall;
  logic [2:0] w_in_full;
  logic [2:0] w_in_empty;
  logic [2:0] w_out_full;
  logic [2:0] w_out_empty;
  logic [2:0] w_in_push;
  logic [2:0] w_in_pop;
  logic [2:0] w_out_push;
  logic [2:0] w_out_pop;
  logic       w_rd_err;
  logic       w_wr_err;

  // A strobe held high across reset never arms, so its fall is ignored.
  assign w_rd_fall = r_read_q & ~core_read & r_rd_arm;
  assign w_wr_fall = r_write_q & ~core_write & r_wr_arm;

  // Per-FIFO status and push/pop decisions; a pop frees room for a push.
  always_comb begin
    w_in_full   = '0;
    w_in_empty  = '0;
    w_out_full  = '0;
    w_out_empty = '0;
    w_in_push   = '0;
    w_in_pop    = '0;
    w_out_push  = '0;
    w_out_pop   = '0;
    for (int i = 0; i < 3; i++) begin
      w_in_full[i]   = (r_in_cnt[i] == CFULL);
      w_in_empty[i]  = (r_in_cnt[i] == '0);
      w_out_full[i]  = (r_out_cnt[i] == CFULL);
      w_out_empty[i] = (r_out_cnt[i] == '0);
      w_in_pop[i]    = w_rd_fall && (core_in_addr == 2'(i))
                       && !w_in_empty[i];
      w_in_push[i]   = ext_wr_en && (ext_wr_port == 2'(i))
                       && (!w_in_full[i] || w_in_pop[i]);
      w_out_pop[i]   = ext_rd_en && (ext_rd_port == 2'(i))
                       && !w_out_empty[i];
      w_out_push[i]  = w_wr_fall && (core_out_addr == 2'(i))
                       && (!w_out_full[i] || w_out_pop[i]);
    end
  end

  assign w_rd_err = w_rd_fall & ~|w_in_pop;
  assign w_wr_err = w_wr_fall & ~|w_out_push;

  // Strobe history, arming and the sticky error flag.
  always_ff @(posedge lclock or negedge reset_n) begin
    if (!reset_n) begin
      r_read_q  <= 1'b0;
      r_write_q <= 1'b0;
      r_rd_arm  <= 1'b0;
      r_wr_arm  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_read_q  <= core_read;
      r_write_q <= core_write;
      if (!core_read)  r_rd_arm <= 1'b1;
      if (!core_write) r_wr_arm <= 1'b1;
      if (w_rd_err || w_wr_err) r_err <= 1'b1;
    end
  end

  // Pointers and counts for all six FIFOs.
  always_ff @(posedge lclock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        r_in_wp[i]   <= '0;
        r_in_rp[i]   <= '0;
        r_in_cnt[i]  <= '0;
        r_out_wp[i]  <= '0;
        r_out_rp[i]  <= '0;
        r_out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_in_push[i]) r_in_wp[i] <= r_in_wp[i] + PONE;
        if (w_in_pop[i])  r_in_rp[i] <= r_in_rp[i] + PONE;
        if (w_in_push[i] && !w_in_pop[i])
          r_in_cnt[i] <= r_in_cnt[i] + CONE;
        else if (!w_in_push[i] && w_in_pop[i])
          r_in_cnt[i] <= r_in_cnt[i] - CONE;
        if (w_out_push[i]) r_out_wp[i] <= r_out_wp[i] + PONE;
        if (w_out_pop[i])  r_out_rp[i] <= r_out_rp[i] + PONE;
        if (w_out_push[i] && !w_out_pop[i])
          r_out_cnt[i] <= r_out_cnt[i] + CONE;
        else if (!w_out_push[i] && w_out_pop[i])
          r_out_cnt[i] <= r_out_cnt[i] - CONE;
      end
    end
  end

  // Storage carries no reset; contents are don't-care when empty.
  always_ff @(posedge lclock) begin
    for (int i = 0; i < 3; i++) begin
      if (w_in_push[i])
        r_in_mem[i][r_in_wp[i]] <= ext_wr_data;
      if (w_out_push[i])
        r_out_mem[i][r_out_wp[i]] <= core_data_out;
    end
  end

  // Head words and per-port status for the addressed FIFOs.
  always_comb begin
    core_data_in = '0;
    ext_rd_data  = '0;
    ext_wr_full  = 1'b1;
    ext_rd_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (core_in_addr == 2'(i) && !w_in_empty[i])
        core_data_in = r_in_mem[i][r_in_rp[i]];
      if (ext_rd_port == 2'(i) && !w_out_empty[i])
        ext_rd_data = r_out_mem[i][r_out_rp[i]];
      if (ext_wr_port == 2'(i))
        ext_wr_full = w_in_full[i];
      if (ext_rd_port == 2'(i))
        ext_rd_empty = w_out_empty[i];
    end
  end

  assign core_in_ready  = ~w_in_empty;
  assign core_out_ready = ~w_out_full;
  assign err            = r_err;

`ifdef PORT_BANK_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic [1:0] w_err_n;
  logic [8:0] w_cnt_sum;

  assign w_err_n   = {1'b0, w_rd_err} + {1'b0, w_wr_err};
  assign w_cnt_sum = {1'b0, r_err_cnt} + {7'b0, w_err_n};

  // Saturating count of core protocol errors.
  always_ff @(posedge lclock or negedge reset_n) begin
    if (!reset_n) r_err_cnt <= '0;
    else          r_err_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_port_bank.sv
// Directed self-checking bench for port_bank.
// Define PORT_BANK_ERR_CNT_EN to also check err_cnt.
`timescale 1ns/1ps
module tb_port_bank;

  logic        lclock = 1'b0;
  logic        reset_n;
  logic        core_read;
  logic [1:0]  core_in_addr;
  logic [2:0]  core_in_ready;
  logic [31:0] core_data_in;
  logic        core_write;
  logic [1:0]  core_out_addr;
  logic [31:0] core_data_out;
  logic [2:0]  core_out_ready;
  logic        ext_wr_en;
  logic [1:0]  ext_wr_port;
  logic [31:0] ext_wr_data;
  logic        ext_wr_full;
  logic        ext_rd_en;
  logic [1:0]  ext_rd_port;
  logic [31:0] ext_rd_data;
  logic        ext_rd_empty;
  logic        err;
`ifdef PORT_BANK_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int passed = 0;

  always #5 lclock = ~lclock;

  port_bank #(.DEPTH(4), .WIDTH(32)) dut (
    .lclock         (lclock),
    .reset_n        (reset_n),
    .core_read      (core_read),
    .core_in_addr   (core_in_addr),
    .core_in_ready  (core_in_ready),
    .core_data_in   (core_data_in),
    .core_write     (core_write),
    .core_out_addr  (core_out_addr),
    .core_data_out  (core_data_out),
    .core_out_ready (core_out_ready),
    .ext_wr_en      (ext_wr_en),
    .ext_wr_port    (ext_wr_port),
    .ext_wr_data    (ext_wr_data),
    .ext_wr_full    (ext_wr_full),
    .ext_rd_en      (ext_rd_en),
    .ext_rd_port    (ext_rd_port),
    .ext_rd_data    (ext_rd_data),
    .ext_rd_empty   (ext_rd_empty),
    .err            (err)
`ifdef PORT_BANK_ERR_CNT_EN
    ,
    .err_cnt        (err_cnt)
`endif
  );

  task automatic tick();
    @(posedge lclock);
    #1;
  endtask

  task automatic ext_write(input logic [1:0] p, input logic [31:0] d);
    ext_wr_port = p;
    ext_wr_data = d;
    ext_wr_en   = 1'b1;
    tick();
    ext_wr_en   = 1'b0;
  endtask

  task automatic ext_read(input logic [1:0] p, output logic [31:0] d);
    ext_rd_port = p;
    ext_rd_en   = 1'b1;
    #1;
    d = ext_rd_data;
    tick();
    ext_rd_en   = 1'b0;
  endtask

  task automatic core_rd(input logic [1:0] a, output logic [31:0] d);
    core_in_addr = a;
    core_read    = 1'b1;
    tick();
    d = core_data_in;
    core_read    = 1'b0;
    tick();
  endtask

  task automatic core_wr(input logic [1:0] a, input logic [31:0] d);
    core_out_addr = a;
    core_data_out = d;
    core_write    = 1'b1;
    tick();
    core_write    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    ext_wr_port = 2'd0;
    ext_rd_port = 2'd0;
    core_in_addr = 2'd0;
    #1;
    checks++;
    if (core_in_ready !== 3'b000)
      $display("FAIL reset_in_ready got %b want 000", core_in_ready);
    else passed++;
    checks++;
    if (core_out_ready !== 3'b111)
      $display("FAIL reset_out_ready got %b want 111", core_out_ready);
    else passed++;
    checks++;
    if (ext_rd_empty !== 1'b1 || ext_wr_full !== 1'b0)
      $display("FAIL reset_ext_flags got empty=%b full=%b want 1 0",
               ext_rd_empty, ext_wr_full);
    else passed++;
    checks++;
    if (core_data_in !== 32'h0 || ext_rd_data !== 32'h0)
      $display("FAIL reset_data got %h %h want 0 0",
               core_data_in, ext_rd_data);
    else passed++;
    checks++;
    if (err !== 1'b0)
      $display("FAIL reset_err got %b want 0", err);
    else passed++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ext_to_core();
    logic [31:0] d;
    ext_write(2'd1, 32'h11);
    checks++;
    if (core_in_ready !== 3'b010)
      $display("FAIL e2c_ready got %b want 010", core_in_ready);
    else passed++;
    ext_write(2'd1, 32'h22);
    core_in_addr = 2'd1;
    #1;
    checks++;
    if (core_data_in !== 32'h11)
      $display("FAIL e2c_head got %h want 11", core_data_in);
    else passed++;
    core_rd(2'd1, d);
    checks++;
    if (d !== 32'h11)
      $display("FAIL e2c_rd1 got %h want 11", d);
    else passed++;
    core_rd(2'd1, d);
    checks++;
    if (d !== 32'h22)
      $display("FAIL e2c_rd2 got %h want 22", d);
    else passed++;
    checks++;
    if (core_in_ready !== 3'b000 || err !== 1'b0)
      $display("FAIL e2c_after got ready=%b err=%b want 000 0",
               core_in_ready, err);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 4; i++) ext_write(2'd0, 32'(i));
    ext_wr_port = 2'd0;
    #1;
    checks++;
    if (ext_wr_full !== 1'b1)
      $display("FAIL ovf_full got %b want 1", ext_wr_full);
    else passed++;
    ext_write(2'd0, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      core_rd(2'd0, d);
      checks++;
      if (d !== 32'(i))
        $display("FAIL ovf_rd%0d got %h want %h", i, d, 32'(i));
      else passed++;
    end
    checks++;
    if (core_in_ready !== 3'b000 || ext_wr_full !== 1'b0 || err !== 1'b0)
      $display("FAIL ovf_drained got ready=%b full=%b err=%b want 000 0 0",
               core_in_ready, ext_wr_full, err);
    else passed++;
  endtask

  task automatic test_core_to_ext();
    logic [31:0] d;
    ext_rd_port = 2'd2;
    #1;
    checks++;
    if (ext_rd_empty !== 1'b1)
      $display("FAIL c2e_pre_empty got %b want 1", ext_rd_empty);
    else passed++;
    core_wr(2'd2, 32'hDEADBEEF);
    checks++;
    if (ext_rd_empty !== 1'b0 || ext_rd_data !== 32'hDEADBEEF)
      $display("FAIL c2e_head got empty=%b data=%h want 0 deadbeef",
               ext_rd_empty, ext_rd_data);
    else passed++;
    ext_read(2'd2, d);
    checks++;
    if (ext_rd_empty !== 1'b1 || ext_rd_data !== 32'h0)
      $display("FAIL c2e_popped got empty=%b data=%h want 1 0",
               ext_rd_empty, ext_rd_data);
    else passed++;
  endtask

  task automatic test_full_simul();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) core_wr(2'd0, 32'hA0 + 32'(i));
    checks++;
    if (core_out_ready !== 3'b110)
      $display("FAIL sim_full got %b want 110", core_out_ready);
    else passed++;
    core_out_addr = 2'd0;
    core_data_out = 32'hA4;
    core_write    = 1'b1;
    tick();
    core_write    = 1'b0;
    ext_read(2'd0, d);
    checks++;
    if (d !== 32'hA0)
      $display("FAIL sim_pop got %h want a0", d);
    else passed++;
    checks++;
    if (core_out_ready !== 3'b110 || err !== 1'b0)
      $display("FAIL sim_count got ready=%b err=%b want 110 0",
               core_out_ready, err);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      ext_read(2'd0, d);
      checks++;
      if (d !== 32'hA0 + 32'(i))
        $display("FAIL sim_order%0d got %h want %h",
                 i, d, 32'hA0 + 32'(i));
      else passed++;
    end
    checks++;
    if (ext_rd_empty !== 1'b1 || core_out_ready !== 3'b111)
      $display("FAIL sim_drained got empty=%b ready=%b want 1 111",
               ext_rd_empty, core_out_ready);
    else passed++;
  endtask

  task automatic test_err();
    logic [31:0] d;
    checks++;
    if (err !== 1'b0)
      $display("FAIL err_pre got %b want 0", err);
    else passed++;
    core_rd(2'd3, d);
    checks++;
    if (err !== 1'b1 || d !== 32'h0)
      $display("FAIL err_addr3 got err=%b data=%h want 1 0", err, d);
    else passed++;
`ifdef PORT_BANK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd1)
      $display("FAIL err_cnt1 got %0d want 1", err_cnt);
    else passed++;
`endif
    core_rd(2'd0, d);
    checks++;
    if (err !== 1'b1 || core_in_ready !== 3'b000)
      $display("FAIL err_empty got err=%b ready=%b want 1 000",
               err, core_in_ready);
    else passed++;
`ifdef PORT_BANK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd2)
      $display("FAIL err_cnt2 got %0d want 2", err_cnt);
    else passed++;
`endif
    ext_write(2'd0, 32'h99);
    core_in_addr = 2'd0;
    #1;
    checks++;
    if (core_data_in !== 32'h99 || core_in_ready !== 3'b001)
      $display("FAIL err_noptr got data=%h ready=%b want 99 001",
               core_data_in, core_in_ready);
    else passed++;
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    ext_write(2'd2, 32'h55);
    ext_write(2'd2, 32'h66);
    core_wr(2'd1, 32'h1234);
    checks++;
    if (core_in_ready !== 3'b101)
      $display("FAIL rif_queued got %b want 101", core_in_ready);
    else passed++;
    core_in_addr = 2'd2;
    core_read    = 1'b1;
    tick();
    reset_n = 1'b0;
    #2;
    ext_rd_port = 2'd1;
    #1;
    checks++;
    if (core_in_ready !== 3'b000 || core_out_ready !== 3'b111)
      $display("FAIL rif_flags got in=%b out=%b want 000 111",
               core_in_ready, core_out_ready);
    else passed++;
    checks++;
    if (ext_rd_empty !== 1'b1 || err !== 1'b0)
      $display("FAIL rif_empty got empty=%b err=%b want 1 0",
               ext_rd_empty, err);
    else passed++;
    tick();
    reset_n = 1'b1;
    tick();
    ext_write(2'd2, 32'h77);
    core_read = 1'b0;
    tick();
    tick();
    checks++;
    if (core_in_ready !== 3'b100 || core_data_in !== 32'h77 || err !== 1'b0)
      $display("FAIL rif_nopop got ready=%b data=%h err=%b want 100 77 0",
               core_in_ready, core_data_in, err);
    else passed++;
    core_rd(2'd2, d);
    checks++;
    if (d !== 32'h77 || core_in_ready !== 3'b000)
      $display("FAIL rif_read got data=%h ready=%b want 77 000",
               d, core_in_ready);
    else passed++;
  endtask

  initial begin
    core_read     = 1'b0;
    core_in_addr  = 2'd0;
    core_write    = 1'b0;
    core_out_addr = 2'd0;
    core_data_out = '0;
    ext_wr_en     = 1'b0;
    ext_wr_port   = 2'd0;
    ext_wr_data   = '0;
    ext_rd_en     = 1'b0;
    ext_rd_port   = 2'd0;
    test_reset();
    test_ext_to_core();
    test_overflow();
    test_core_to_ext();
    test_full_simul();
    test_err();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/port_bank.md
PORT_BANK -- requirements
Module: port_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the entries per FIFO (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the data word width.
REQ-003 SHALL have port lclock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port core_read, input, 1, the core read strobe (level, at least 1 cycle high).
REQ-006 SHALL have port core_in_addr, input, 2, the input port selected by the core.
REQ-007 SHALL have port core_in_ready, output, 3, where bit i means input FIFO i is non-empty.
REQ-008 SHALL have port core_data_in, output, WIDTH, the head word of input FIFO core_in_addr.
REQ-009 SHALL have port core_write, input, 1, the core write strobe (level, at least 1 cycle high).
REQ-010 SHALL have port core_out_addr, input, 2, the output port selected by the core.
REQ-011 SHALL have port core_data_out, input, WIDTH, the word written by the core.
REQ-012 SHALL have port core_out_ready, output, 3, where bit i means output FIFO i is not full.
REQ-013 SHALL have ports ext_wr_en (in, 1), ext_wr_port (in, 2), ext_wr_data (in, WIDTH) and ext_wr_full (out, 1): the external producer interface.
REQ-014 SHALL have ports ext_rd_en (in, 1), ext_rd_port (in, 2), ext_rd_data (out, WIDTH) and ext_rd_empty (out, 1): the external consumer interface.
REQ-015 SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-016 SHALL implement three input FIFOs (ext -> core) and three output FIFOs (core -> ext), each DEPTH deep, with read/write pointers and a count.
REQ-017 SHALL register core_read and core_write once (read_q, write_q); a falling edge is read_q=1 with core_read=0, and likewise for write.
REQ-018 SHALL pop input FIFO core_in_addr on the edge detecting the read falling edge, so core_data_in stays stable for the whole high phase of core_read.
REQ-019 SHALL push core_data_out into output FIFO core_out_addr on the edge detecting the write falling edge.
REQ-020 SHALL drive core_data_in combinationally from the selected head, and drive it 0 when the FIFO is empty or the address is 3.
REQ-021 SHALL derive core_in_ready and core_out_ready from registered counts only, so they update the cycle after a push or pop.
REQ-022 SHALL push ext_wr_data into input FIFO ext_wr_port when ext_wr_en=1 and the FIFO is not full; otherwise the push is dropped.
REQ-023 SHALL pop output FIFO ext_rd_port when ext_rd_en=1 and the FIFO is non-empty; ext_rd_data is the combinational head, or 0 when empty.
REQ-024 SHALL drive ext_wr_full and ext_rd_empty combinationally for the currently addressed port, and drive both to 1 for address 3.
REQ-025 SHALL, on a same-cycle push and pop to one FIFO, perform both and leave the count unchanged; this applies when full too.
REQ-026 SHALL wrap pointers modulo DEPTH.
REQ-027 SHALL set err on a core pop from an empty FIFO, a core push to a full FIFO, or any core access to address 3; the access itself is ignored.

Reset
REQ-028 SHALL, on reset_n=0, immediately clear all pointers, counts, read_q, write_q and err; FIFO contents become don't-care.
REQ-029 SHALL hold the following outputs during reset: core_in_ready=000, core_out_ready=111, ext_rd_empty=1, ext_wr_full=0 (ports 0..2), core_data_in=0, ext_rd_data=0.
REQ-030 SHALL discard an in-flight strobe when reset asserts mid-operation; no push or pop occurs on release.

Configuration
REQ-031 SHALL, with PORT_BANK_ERR_CNT_EN defined, add output err_cnt[7:0]: a saturating count of the REQ-027 events, cleared by reset.
REQ-032 SHALL, without PORT_BANK_ERR_CNT_EN, omit err_cnt and its counter entirely; err behaviour is unchanged.

Verification
REQ-033 SHALL cover: ext writes 0x11 then 0x22 to port 1 -> core_in_ready=010 one cycle later; a core read pulse at addr 1 sees 0x11, and the next pulse sees 0x22.
REQ-034 SHALL cover: 5 ext writes to port 0 with DEPTH=4 -> ext_wr_full=1 after 4, the 5th is dropped, and core reads return words 1..4.
REQ-035 SHALL cover: core write pulse with data 0xDEADBEEF at out_addr 2 -> ext_rd_empty=0 for port 2 and ext_rd_data=0xDEADBEEF.
REQ-036 SHALL cover: output FIFO 0 full plus a same-cycle core push and ext pop -> count stays 4, core_out_ready[0] stays 0, and the order is preserved.
REQ-037 SHALL cover: core read at addr 3, or at an empty addr 0 -> err=1, no pointer changes, and err_cnt=2 when the macro is defined.
REQ-038 SHALL cover: reset_n pulsed low while core_read is high with 2 words queued -> all FIFOs empty, core_out_ready=111, and no pop after release.
